wc_pad_serdes: RTL and testbench
================================

WC_PAD_SERDES -- requirements
Module: wc_pad_serdes

Interface
REQ-001 Parameter DW, default 10, bit width of one data word.
REQ-002 Parameter NIN, default 9, number of input words per core operand.
REQ-003 Parameter NOUT, default 5, number of output words per core result.
REQ-004 Parameter LANES, default 3, words carried per pad beat; 1 <= LANES <= max(NIN,NOUT).
REQ-005 Parameter CORE_LAT, default 2, cycles from a core_D update to a valid core_Z; CORE_LAT >= 1.
REQ-006 Derived: IB = ceil(NIN/LANES) input beats; OB = ceil(NOUT/LANES) output beats.
REQ-007 clk  input  1  single clock; all state on rising edge.
REQ-008 rst  input  1  reset; asynchronous, active-low.
REQ-009 in_valid  input  1  in_data beat is valid.
REQ-010 in_ready  output  1  block accepts an input beat.
REQ-011 in_data  input  DW*LANES  input beat; lane l = bits [l*DW +: DW].
REQ-012 out_valid  output  1  out_data beat is valid.
REQ-013 out_ready  input  1  downstream accepts the output beat.
REQ-014 out_data  output  DW*LANES  output beat, same lane layout.
REQ-015 core_D  output  DW*NIN  operand vector to the Winograd core; word i = bits [i*DW +: DW].
REQ-016 core_Z  input  DW*NOUT  result vector from the core, same word layout.
REQ-017 busy  output  1  high in WAIT or UNLOAD.

Function
REQ-018 The FSM SHALL have three states: LOAD (reset state), WAIT, UNLOAD.
REQ-019 An input handshake SHALL occur on a rising edge with in_valid=1 and in_ready=1; an output handshake with out_valid=1 and out_ready=1.
REQ-020 in_ready SHALL equal 1 in LOAD only, and 0 in WAIT and UNLOAD.
REQ-021 Input beat k (0..IB-1), lane l SHALL map to word k*LANES+l; lanes with index >= NIN in the last beat SHALL be ignored.
REQ-022 Beats 0..IB-2 SHALL be staged internally; core_D SHALL not change until the last beat's handshake, when all NIN words SHALL update on that same edge (atomic update).
REQ-023 On the last input handshake, the FSM SHALL go to WAIT and load a latency counter with CORE_LAT.
REQ-024 In WAIT, the block SHALL sample core_Z into an output buffer on the edge exactly CORE_LAT cycles after the core_D update edge, then enter UNLOAD.
REQ-025 In UNLOAD, out_valid SHALL be 1 and out_data SHALL present beat j: lane l = result word j*LANES+l, with lanes >= NOUT driven to 0.
REQ-026 Each output handshake SHALL advance j; out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-027 On the handshake of beat OB-1, the FSM SHALL return to LOAD with the beat counter at 0; out_valid SHALL be 0 in the next cycle.
REQ-028 in_valid while in_ready=0 SHALL have no effect; out_ready while out_valid=0 SHALL have no effect.
REQ-029 core_D SHALL hold its last value through WAIT, UNLOAD and the next LOAD until the next atomic update.
REQ-030 Throughput with no backpressure: one operation per IB+CORE_LAT+OB cycles.

Reset
REQ-031 While rst=0: state=LOAD, beat counters=0, latency counter=0, core_D=0, staging and output buffers=0, out_valid=0, out_data=0, busy=0, in_ready=0.
REQ-032 Reset asserted mid-operation (any state) SHALL abort the operation immediately; no partial result SHALL be emitted afterwards.
REQ-033 in_ready SHALL rise in the first cycle in which rst=1.

Verification
REQ-034 Defaults, core stub with Z word i = D word i + D word i+4 registered CORE_LAT=2: beats {1,2,3},{4,5,6},{7,8,9} -> out beats {6,8,10},{12,14,0}.
REQ-035 Staging: after beats 0 and 1 only, core_D = 0 (after reset); on beat 2 handshake, core_D words 0..8 = 1..9 on the same edge.
REQ-036 Backpressure: out_ready held 0 for 5 cycles in UNLOAD -> out_valid stays 1, out_data stays {6,8,10}, in_ready stays 0.
REQ-037 Reset in WAIT one cycle after the last input beat -> out_valid never rises, core_D=0, in_ready=1 the first cycle after rst returns high.
REQ-038 Parameter sweep LANES=1 (IB=9, OB=5) and LANES=4 (IB=3, OB=2, ignored lanes 9..11 driven 0xFF) -> identical result words to the default-parameter run.
REQ-039 Back-to-back operations with in_valid and out_ready held 1 -> one result every IB+CORE_LAT+OB = 7 cycles; no beat dropped or duplicated.

Source files
------------

// File: rtl/wc_pad_serdes.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wc_pad_serdes                                                     |
// | Function : lane-narrow pad serializer/deserializer around a Winograd core    |
// | Revision : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module wc_pad_serdes #(
  parameter int DW       = 10,
  parameter int NIN      = 9,
  parameter int NOUT     = 5,
  parameter int LANES    = 3,
  parameter int CORE_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW*LANES-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW*LANES-1:0]  out_data,
  output logic [DW*NIN-1:0]    core_D,
  input  logic [DW*NOUT-1:0]   core_Z,
  output logic                 busy
);

  localparam int c_IB  = (NIN + LANES - 1) / LANES;
  localparam int c_OB  = (NOUT + LANES - 1) / LANES;
  localparam int c_IBW = $clog2(c_IB + 1);
  localparam int c_OBW = $clog2(c_OB + 1);
  localparam int c_LW  = $clog2(CORE_LAT + 1);

  localparam logic [c_IBW-1:0] c_IB_LAST = c_IBW'(c_IB - 1);
  localparam logic [c_OBW-1:0] c_OB_LAST = c_OBW'(c_OB - 1);
  localparam logic [c_LW-1:0]  c_LAT     = c_LW'(CORE_LAT);
  localparam logic [c_LW-1:0]  c_LAT_ONE = c_LW'(1);

  localparam logic [1:0] c_LOAD   = 2'd0;
  localparam logic [1:0] c_WAIT   = 2'd1;
  localparam logic [1:0] c_UNLOAD = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [c_IBW-1:0] r_in_beat;
  logic [c_OBW-1:0] r_out_beat;
  logic [c_LW-1:0]  r_lat;
  logic [DW-1:0]    r_stage [NIN];
  logic [DW-1:0]    r_core  [NIN];
  logic [DW-1:0]    r_obuf  [NOUT];

  logic w_in_fire;
  logic w_out_fire;
  logic w_in_last;
  logic w_out_last;
  logic w_lat_done;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  assign w_in_last  = (r_in_beat == c_IB_LAST);
  assign w_out_last = (r_out_beat == c_OB_LAST);
  assign w_lat_done = (r_lat == c_LAT_ONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= c_LOAD;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_LOAD:   if (w_in_fire && w_in_last)   w_next = c_WAIT;
      c_WAIT:   if (w_lat_done)               w_next = c_UNLOAD;
      c_UNLOAD: if (w_out_fire && w_out_last) w_next = c_LOAD;
      default:                                w_next = c_LOAD;
    endcase
  end

  // in_ready is qualified by rst so it stays low while reset is held
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      c_LOAD:   in_ready = rst;
      c_WAIT:   busy     = 1'b1;
      c_UNLOAD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    out_data = '0;
    if (r_state == c_UNLOAD) begin
      for (int l = 0; l < LANES; l++) begin
        for (int w = 0; w < NOUT; w++) begin
          if (w == int'(r_out_beat) * LANES + l) out_data[l*DW +: DW] = r_obuf[w];
        end
      end
    end
  end

  // Early beats land in r_stage; the core operand only moves on the last beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_beat <= '0;
      for (int i = 0; i < NIN; i++) begin
        r_stage[i] <= '0;
        r_core[i]  <= '0;
      end
    end else if (w_in_fire) begin
      if (w_in_last) begin
        r_in_beat <= '0;
        for (int i = 0; i < NIN; i++) begin
          if (i / LANES == c_IB - 1) r_core[i] <= in_data[(i % LANES)*DW +: DW];
          else                       r_core[i] <= r_stage[i];
        end
      end else begin
        r_in_beat <= r_in_beat + 1'b1;
        for (int i = 0; i < NIN; i++) begin
          if (i / LANES == int'(r_in_beat)) r_stage[i] <= in_data[(i % LANES)*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lat <= '0;
      for (int w = 0; w < NOUT; w++) r_obuf[w] <= '0;
    end else if (r_state == c_LOAD) begin
      if (w_in_fire && w_in_last) r_lat <= c_LAT;
    end else if (r_state == c_WAIT) begin
      if (w_lat_done) begin
        r_lat <= '0;
        for (int w = 0; w < NOUT; w++) r_obuf[w] <= core_Z[w*DW +: DW];
      end else begin
        r_lat <= r_lat - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            r_out_beat <= '0;
    else if (w_out_fire) r_out_beat <= w_out_last ? '0 : r_out_beat + 1'b1;
  end

  for (genvar gi = 0; gi < NIN; gi++) begin : g_core_d
    assign core_D[gi*DW +: DW] = r_core[gi];
  end

endmodule
`default_nettype wire

// File: tb/tb_wc_pad_serdes.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_wc_pad_serdes                                                  |
// | Function : directed self-checking bench for wc_pad_serdes                    |
// | Revision : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_wc_pad_serdes;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  // default-parameter instance (LANES=3)
  logic        m_iv = 1'b0, m_or = 1'b0;
  logic        m_ir, m_ov, m_busy;
  logic [29:0] m_id = '0;
  logic [29:0] m_od;
  logic [89:0] m_D;
  logic [49:0] m_Z;

  // LANES=1 instance
  logic        a_iv = 1'b0, a_or = 1'b0;
  logic        a_ir, a_ov, a_busy;
  logic [9:0]  a_id = '0;
  logic [9:0]  a_od;
  logic [89:0] a_D;
  logic [49:0] a_Z;

  // LANES=4 instance
  logic        b_iv = 1'b0, b_or = 1'b0;
  logic        b_ir, b_ov, b_busy;
  logic [39:0] b_id = '0;
  logic [39:0] b_od;
  logic [89:0] b_D;
  logic [49:0] b_Z;

  wc_pad_serdes #(.DW(10), .NIN(9), .NOUT(5), .LANES(3), .CORE_LAT(2)) u_main (
    .clk(clk), .rst(rst), .in_valid(m_iv), .in_ready(m_ir), .in_data(m_id),
    .out_valid(m_ov), .out_ready(m_or), .out_data(m_od),
    .core_D(m_D), .core_Z(m_Z), .busy(m_busy));

  wc_pad_serdes #(.DW(10), .NIN(9), .NOUT(5), .LANES(1), .CORE_LAT(2)) u_l1 (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
    .core_D(a_D), .core_Z(a_Z), .busy(a_busy));

  wc_pad_serdes #(.DW(10), .NIN(9), .NOUT(5), .LANES(4), .CORE_LAT(2)) u_l4 (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
    .core_D(b_D), .core_Z(b_Z), .busy(b_busy));

  // Core stub: Z[i] = D[i] + D[i+4], one register so Z is valid CORE_LAT=2 edges after D
  function automatic logic [49:0] core_fn(input logic [89:0] d);
    logic [49:0] z;
    z = '0;
    for (int i = 0; i < 5; i++) z[i*10 +: 10] = d[i*10 +: 10] + d[(i+4)*10 +: 10];
    return z;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_Z <= '0;
      a_Z <= '0;
      b_Z <= '0;
    end else begin
      m_Z <= core_fn(m_D);
      a_Z <= core_fn(a_D);
      b_Z <= core_fn(b_D);
    end
  end

  // operand vector whose word i is base+i+1
  function automatic logic [89:0] d_of(input int base);
    logic [89:0] d;
    d = '0;
    for (int i = 0; i < 9; i++) d[i*10 +: 10] = 10'(base + i + 1);
    return d;
  endfunction

  function automatic logic [29:0] beat3(input int a, input int b, input int c);
    return {10'(c), 10'(b), 10'(a)};
  endfunction

  // three-lane output beat j of a result vector, lanes past word 4 zero
  function automatic logic [29:0] obeat(input logic [49:0] z, input int j);
    logic [29:0] r;
    r = '0;
    for (int l = 0; l < 3; l++)
      if (j*3 + l < 5) r[l*10 +: 10] = z[(j*3 + l)*10 +: 10];
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  int          k, ob, last_c, seen, a_k, a_ob, b_k, b_ob;
  logic [89:0] dv;
  logic [9:0]  a_res [8];
  logic [9:0]  b_res [8];

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 128'(m_ir), 128'(0));
    check("rst_out_valid", 128'(m_ov), 128'(0));
    check("rst_busy", 128'(m_busy), 128'(0));
    check("rst_core_D", 128'(m_D), 128'(0));
    check("rst_out_data", 128'(m_od), 128'(0));
    rst = 1'b1;
    #1;
    check("rst_release_in_ready", 128'(m_ir), 128'(1));

    // staging, atomic update, latency
    m_iv = 1'b1; m_id = beat3(1, 2, 3);
    @(negedge clk);
    check("stage_b0_core_D", 128'(m_D), 128'(0));
    check("stage_b0_in_ready", 128'(m_ir), 128'(1));
    m_id = beat3(4, 5, 6);
    @(negedge clk);
    check("stage_b1_core_D", 128'(m_D), 128'(0));
    m_id = beat3(7, 8, 9);
    @(negedge clk);
    check("atomic_core_D", 128'(m_D), 128'(d_of(0)));
    check("wait_busy", 128'(m_busy), 128'(1));
    check("wait_in_ready", 128'(m_ir), 128'(0));
    m_iv = 1'b0;
    @(negedge clk);
    check("wait_out_valid", 128'(m_ov), 128'(0));
    @(negedge clk);
    check("unload_out_valid", 128'(m_ov), 128'(1));
    check("unload_beat0", 128'(m_od), 128'(beat3(6, 8, 10)));

    // backpressure, with input ignored while not ready
    m_iv = 1'b1; m_id = beat3(77, 77, 77);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 128'(m_ov), 128'(1));
      check("bp_out_data", 128'(m_od), 128'(beat3(6, 8, 10)));
      check("bp_in_ready", 128'(m_ir), 128'(0));
    end
    check("bp_core_D_held", 128'(m_D), 128'(d_of(0)));
    m_iv = 1'b0; m_or = 1'b1;
    @(negedge clk);
    check("unload_beat1", 128'(m_od), 128'(beat3(12, 14, 0)));
    check("unload_beat1_valid", 128'(m_ov), 128'(1));
    @(negedge clk);
    check("done_out_valid", 128'(m_ov), 128'(0));
    check("done_in_ready", 128'(m_ir), 128'(1));
    check("done_busy", 128'(m_busy), 128'(0));
    check("done_core_D_held", 128'(m_D), 128'(d_of(0)));

    // back-to-back: three operations, data bases 0, 20, 40
    m_iv = 1'b1; m_or = 1'b1; k = 0; ob = 0; last_c = 0;
    for (int c = 0; c < 40; c++) begin
      if (m_ov) begin
        check("b2b_beat", 128'(m_od), 128'(obeat(core_fn(d_of(20 * (ob / 2))), ob % 2)));
        if (ob % 2 == 0) begin
          if (ob > 0) check("b2b_period", 128'(c - last_c), 128'(7));
          last_c = c;
        end
        ob++;
      end
      if (k >= 9) m_iv = 1'b0;
      else if (m_ir) begin
        m_iv = 1'b1;
        dv   = d_of(20 * (k / 3));
        m_id = dv[(k % 3)*30 +: 30];
        k++;
      end
      @(negedge clk);
    end
    check("b2b_beat_count", 128'(ob), 128'(6));
    m_iv = 1'b0; m_or = 1'b0;

    // reset in WAIT aborts the operation
    for (int i = 0; i < 3; i++) begin
      m_iv = 1'b1;
      m_id = beat3(100 + 3*i + 1, 100 + 3*i + 2, 100 + 3*i + 3);
      @(negedge clk);
    end
    m_iv = 1'b0;
    check("abort_pre_busy", 128'(m_busy), 128'(1));
    rst = 1'b0;
    #1;
    check("abort_core_D", 128'(m_D), 128'(0));
    check("abort_in_ready_low", 128'(m_ir), 128'(0));
    check("abort_busy", 128'(m_busy), 128'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_in_ready_rise", 128'(m_ir), 128'(1));
    m_or = 1'b1; seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (m_ov) seen = 1;
    end
    check("abort_no_output", 128'(seen), 128'(0));
    check("abort_core_D_after", 128'(m_D), 128'(0));
    m_or = 1'b0;

    // parameter sweep: LANES=1 and LANES=4 with same operands 1..9
    a_or = 1'b1; b_or = 1'b1;
    a_k = 0; a_ob = 0; b_k = 0; b_ob = 0;
    for (int i = 0; i < 8; i++) begin
      a_res[i] = '0;
      b_res[i] = 10'h3AA;
    end
    for (int c = 0; c < 40; c++) begin
      if (a_ov && a_ob < 8) begin
        a_res[a_ob] = a_od;
        a_ob++;
      end
      if (b_ov && b_ob < 2) begin
        for (int l = 0; l < 4; l++) b_res[b_ob*4 + l] = b_od[l*10 +: 10];
        b_ob++;
      end
      if (a_k >= 9) a_iv = 1'b0;
      else if (a_ir) begin
        a_iv = 1'b1;
        a_id = 10'(a_k + 1);
        a_k++;
      end
      if (b_k >= 3) b_iv = 1'b0;
      else if (b_ir) begin
        b_iv = 1'b1;
        for (int l = 0; l < 4; l++)
          b_id[l*10 +: 10] = (b_k*4 + l < 9) ? 10'(b_k*4 + l + 1) : 10'h0FF;
        b_k++;
      end
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      check("l1_result", 128'(a_res[i]), 128'(6 + 2*i));
      check("l4_result", 128'(b_res[i]), 128'(6 + 2*i));
    end
    for (int i = 5; i < 8; i++) check("l4_pad_lane_zero", 128'(b_res[i]), 128'(0));
    check("l1_beat_count", 128'(a_ob), 128'(5));
    check("l4_beat_count", 128'(b_ob), 128'(2));
    check("l1_core_D", 128'(a_D), 128'(d_of(0)));
    check("l4_core_D", 128'(b_D), 128'(d_of(0)));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
